fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction-fetch front end of the 5-stage pipeline. It is the producer that drives PC_in and Instruction_in of the IF stage pipeline register.
- Owns the program counter and issues requests to instruction memory over a variable-latency req/ready handshake.
- Honours freeze by holding its output instruction, and honours branch redirects by squashing the fetch in flight.
- When no instruction is available, presents a bubble (all-zero instruction/PC, the same encoding the pipeline registers store on flush).

Parameters:
ADDR_W, 32, width of PC and memory address
DATA_W, 32, instruction width
RESET_PC, 32'h0, first fetch address after reset
PC_STEP, 4, PC increment per sequential instruction

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  asynchronous, active-low reset (rst=0 resets)
freeze  in  1  downstream stall; output instruction must be held
branch_taken  in  1  redirect request from EXE
branch_addr  in  ADDR_W  redirect target
imem_req  out  1  memory request valid
imem_addr  out  ADDR_W  request address, stable while imem_req=1 and imem_ready=0
imem_ready  in  1  memory accepts request and returns data this cycle
imem_rdata  in  DATA_W  instruction, valid when imem_ready=1
PC_out  out  ADDR_W  fetched address + PC_STEP; 0 when fetch_valid=0
Instruction_out  out  DATA_W  fetched instruction; 0 when fetch_valid=0
fetch_valid  out  1  PC_out/Instruction_out carry a real instruction
fetch_stall  out  1  equals ~fetch_valid; IF register receives a bubble

Behaviour:
- Registers:
  - state: IDLE, FETCH, HOLD, DROP.
  - pc: address of the outstanding or next request.
  - tgt: pending redirect target.
  - hold_inst, hold_pc: captured output.
- Reset (rst=0, asynchronous): state=IDLE, pc=RESET_PC, tgt=0, hold regs=0. All outputs read 0, including imem_req=0. IDLE goes to FETCH on the first posedge after rst rises.
- IDLE:
  - imem_req=0, fetch_valid=0.
  - If branch_taken: pc<=branch_addr.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - fetch_valid = imem_ready & ~branch_taken. Instruction_out bypasses imem_rdata combinationally, so a zero-wait memory gives 1 instruction/cycle and a 1-cycle fetch latency.
  - branch_taken & imem_ready: pc<=branch_addr; stay in FETCH; the returned data is discarded.
  - branch_taken & ~imem_ready: tgt<=branch_addr; go to DROP.
  - ~branch_taken & imem_ready & ~freeze: pc<=pc+PC_STEP; stay in FETCH (instruction consumed).
  - ~branch_taken & imem_ready & freeze: hold_inst<=imem_rdata, hold_pc<=pc+PC_STEP, pc<=pc+PC_STEP; go to HOLD.
  - ~imem_ready: no change; bubble output.
- HOLD:
  - imem_req=0. fetch_valid = ~branch_taken. Outputs hold_inst/hold_pc, stable for as long as freeze=1.
  - branch_taken: pc<=branch_addr; go to FETCH; the held instruction is squashed.
  - ~freeze: consumed; go to FETCH.
- DROP:
  - imem_req=1, imem_addr=pc (the old address; the handshake is never abandoned). fetch_valid=0.
  - branch_taken: tgt<=branch_addr (latest redirect wins).
  - imem_ready: pc <= branch_taken ? branch_addr : tgt; go to FETCH; the data is discarded.
- Priority: reset > branch_taken > freeze > normal advance.
- PC arithmetic is modulo 2^ADDR_W: 32'hFFFF_FFFC + 4 wraps to 0.
- Consumption is defined as posedge with fetch_valid=1 & freeze=0, and exactly one instruction is delivered per consumption. With freeze=1 and fetch_valid=0 nothing is lost.
- Reset asserted mid-request drops imem_req immediately. The memory must tolerate a withdrawn request during reset.

Decomposition:
- The shared pipeline package holds ADDR_W/DATA_W defaults, RESET_PC, PC_STEP, the NOP/bubble encoding (all-zero), and the fetch state enum.
- No sub-module is needed; the PC register may reuse the existing 32-bit enable register cell (Reg32) with async active-low reset.

Test Plan:
- Zero-wait memory (ready=1 always), no freeze, 4 cycles after reset → imem_addr 0,4,8,C on consecutive cycles; PC_out 4,8,C,10; fetch_valid=1 each cycle.
- Memory latency 2 (ready on 2nd cycle of each req) → fetch_valid pulses every 2nd cycle; bubble cycles show Instruction_out=0, PC_out=0, fetch_stall=1.
- freeze=1 for 3 cycles while FETCH returns 0xE3A01005 @pc 8 → HOLD, outputs 0xE3A01005/0xC stable for 3 cycles, imem_req=0; then freeze=0 → next request at addr 0xC.
- branch_taken to 0x40 with latency-3 request at 0x10 outstanding → DROP, imem_addr stays 0x10 until ready, no valid output, next request at 0x40.
- branch_taken (0x80) and freeze asserted together in HOLD → held instruction squashed, next fetch at 0x80.
- Async reset pulse mid-DROP → outputs 0 and imem_req=0 immediately; after release: one IDLE cycle, then fetch at RESET_PC; pc wrap check 0xFFFFFFFC → next 0x0.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared pipeline definitions for the instruction-fetch front end.
//   FU_ADDR_W / FU_DATA_W : default PC/address and instruction widths
//   FU_RESET_PC           : first fetch address after reset
//   FU_PC_STEP            : PC increment per sequential instruction
//   FU_BUBBLE             : all-zero NOP/bubble encoding used on flush/stall
//   fetch_state_t         : fetch controller states
package fetch_unit_pkg;

  localparam int unsigned FU_ADDR_W   = 32;
  localparam int unsigned FU_DATA_W   = 32;
  localparam logic [31:0] FU_RESET_PC = 32'h0000_0000;
  localparam int unsigned FU_PC_STEP  = 4;
  localparam logic [31:0] FU_BUBBLE   = '0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DROP  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues requests to instruction
// memory over a variable-latency req/ready handshake and feeds the IF
// pipeline register.
// Ports:
//   clk, rst              : clock, asynchronous active-low reset
//   freeze                : downstream stall, output instruction is held
//   branch_taken/_addr    : redirect request and target from EXE
//   imem_req/_addr        : memory request and address
//   imem_ready/_rdata     : memory accept + returned instruction
//   PC_out/Instruction_out: fetched address + PC_STEP and instruction (0 = bubble)
//   fetch_valid/_stall    : real instruction present / bubble presented
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned       ADDR_W   = FU_ADDR_W,
  parameter int unsigned       DATA_W   = FU_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(FU_RESET_PC),
  parameter int unsigned       PC_STEP  = FU_PC_STEP
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_addr,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [ADDR_W-1:0] PC_out,
  output logic [DATA_W-1:0] Instruction_out,
  output logic              fetch_valid,
  output logic              fetch_stall
);

  fetch_state_t      r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_pc, w_pc_nxt;
  logic [ADDR_W-1:0] r_tgt, w_tgt_nxt;
  logic [DATA_W-1:0] r_hold_inst, w_hold_inst_nxt;
  logic [ADDR_W-1:0] r_hold_pc, w_hold_pc_nxt;
  logic [ADDR_W-1:0] w_pc_inc;

  // Modulo 2^ADDR_W: the top address wraps to 0.
  assign w_pc_inc = r_pc + ADDR_W'(PC_STEP);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_pc        <= RESET_PC;
      r_tgt       <= '0;
      r_hold_inst <= '0;
      r_hold_pc   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_tgt       <= w_tgt_nxt;
      r_hold_inst <= w_hold_inst_nxt;
      r_hold_pc   <= w_hold_pc_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_tgt_nxt       = r_tgt;
    w_hold_inst_nxt = r_hold_inst;
    w_hold_pc_nxt   = r_hold_pc;
    imem_req        = 1'b0;
    imem_addr       = '0;
    fetch_valid     = 1'b0;
    PC_out          = ADDR_W'(FU_BUBBLE);
    Instruction_out = DATA_W'(FU_BUBBLE);

    unique case (r_state)
      ST_IDLE: begin
        w_state_nxt = ST_FETCH;
        if (branch_taken) w_pc_nxt = branch_addr;
      end

      ST_FETCH: begin
        imem_req  = 1'b1;
        imem_addr = r_pc;
        if (branch_taken) begin
          if (imem_ready) begin
            w_pc_nxt = branch_addr;
          end else begin
            // Request cannot be withdrawn: park the target until it completes.
            w_tgt_nxt   = branch_addr;
            w_state_nxt = ST_DROP;
          end
        end else if (imem_ready) begin
          // Zero-wait path: returned data bypasses straight to the output.
          fetch_valid     = 1'b1;
          PC_out          = w_pc_inc;
          Instruction_out = imem_rdata;
          w_pc_nxt        = w_pc_inc;
          if (freeze) begin
            w_hold_inst_nxt = imem_rdata;
            w_hold_pc_nxt   = w_pc_inc;
            w_state_nxt     = ST_HOLD;
          end
        end
      end

      ST_HOLD: begin
        if (branch_taken) begin
          w_pc_nxt    = branch_addr;
          w_state_nxt = ST_FETCH;
        end else begin
          fetch_valid     = 1'b1;
          PC_out          = r_hold_pc;
          Instruction_out = r_hold_inst;
          if (!freeze) w_state_nxt = ST_FETCH;
        end
      end

      ST_DROP: begin
        imem_req  = 1'b1;
        imem_addr = r_pc;
        if (branch_taken) w_tgt_nxt = branch_addr;
        if (imem_ready) begin
          // A redirect arriving on the completing cycle beats the parked one.
          w_pc_nxt    = branch_taken ? branch_addr : r_tgt;
          w_state_nxt = ST_FETCH;
        end
      end

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign fetch_stall = ~fetch_valid;

endmodule
